pe_ec_sched: RTL and testbench

- Sequencing controller for one binary conv/max-pool/binarize PE.
- For each output position of a layer it sweeps all output channels. Per channel it issues the window, weight and norm_ref reads and pulses the PE `in_en`. It then packs the returned binary activations (and optionally pool indices) into one N_OUT_CH-bit word per position.
- Sits between the layer sequencer (start/done), the feature-map/weight/norm-ref memories and the downstream activation buffer (valid/ready).

---
 rtl/pe_ec_sched_pkg.sv | 21 ++
 rtl/pe_ec_sched_if.sv | 19 +
 rtl/pe_sched_pack.sv | 87 ++++++++
 rtl/pe_ec_sched.sv | 158 +++++++++++++++
 tb/tb_pe_ec_sched.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/pe_ec_sched_pkg.sv
// Shared definitions for the PE sequencing controller: FSM encoding and width defaults.
package pe_ec_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } sched_state_t;

    localparam int N_OUT_CH_DEF     = 64;
    localparam int PINDEX_WIDTH_DEF = 2;

    // A single-channel build still needs a one-bit address.
    function automatic int ch_width(input int n_ch);
        return (n_ch > 1) ? $clog2(n_ch) : 1;
    endfunction

    localparam int CH_WIDTH_DEF = ch_width(N_OUT_CH_DEF);

endpackage

// File: rtl/pe_ec_sched_if.sv
// Packed-activation output stream from the scheduler to the activation buffer.
interface pe_ec_sched_if
    import pe_ec_sched_pkg::*;
#(
    parameter int N_OUT_CH     = N_OUT_CH_DEF,
    parameter int POS_WIDTH    = 10,
    parameter int PINDEX_WIDTH = PINDEX_WIDTH_DEF
);
    logic                             out_valid;
    logic                             out_ready;
    logic [N_OUT_CH-1:0]              out_word;
    logic [POS_WIDTH-1:0]             out_pos;
    logic [N_OUT_CH*PINDEX_WIDTH-1:0] out_pindex;

    modport master (output out_valid, output out_word, output out_pos, output out_pindex,
                    input  out_ready);
    modport slave  (input  out_valid, input  out_word, input  out_pos, input  out_pindex,
                    output out_ready);
endinterface

// File: rtl/pe_sched_pack.sv
// Stage-2 shift/pack register plus single-entry output register with valid/ready.
// PE_SCHED_PINDEX_EN adds the parallel pool-index pack path; otherwise o_pindex is 0.
module pe_sched_pack
    import pe_ec_sched_pkg::*;
#(
    parameter int N_OUT_CH     = N_OUT_CH_DEF,
    parameter int POS_WIDTH    = 10,
    parameter int PINDEX_WIDTH = PINDEX_WIDTH_DEF
)(
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             i_adv,
    input  logic                             i_in_en,
    input  logic                             i_last,
    input  logic [POS_WIDTH-1:0]             i_pos,
    input  logic                             i_data,
    input  logic [PINDEX_WIDTH-1:0]          i_pindex,
    input  logic                             i_ready,
    output logic                             o_valid,
    output logic [N_OUT_CH-1:0]              o_word,
    output logic [POS_WIDTH-1:0]             o_pos,
    output logic [N_OUT_CH*PINDEX_WIDTH-1:0] o_pindex
);
    logic                 r_valid;
    logic [N_OUT_CH-1:0]  r_shift;
    logic [N_OUT_CH-1:0]  r_word;
    logic [POS_WIDTH-1:0] r_pos;
    logic [N_OUT_CH-1:0]  w_shift_next;
    logic                 w_shift_en;

    // Channel 0 enters first, so after N shifts it sits at the MSB.
    assign w_shift_next = {r_shift[N_OUT_CH-2:0], i_data};
    assign w_shift_en   = i_adv && i_in_en;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_shift <= '0;
            r_word  <= '0;
            r_pos   <= '0;
        end else begin
            if (w_shift_en) begin
                r_shift <= w_shift_next;
            end
            if (w_shift_en && i_last) begin
                r_valid <= 1'b1;
                r_word  <= w_shift_next;
                r_pos   <= i_pos;
            end else if (r_valid && i_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_word  = r_word;
    assign o_pos   = r_pos;

`ifdef PE_SCHED_PINDEX_EN
    localparam int PW_TOTAL = N_OUT_CH * PINDEX_WIDTH;

    logic [PW_TOTAL-1:0] r_pshift;
    logic [PW_TOTAL-1:0] r_pword;
    logic [PW_TOTAL-1:0] w_pshift_next;

    assign w_pshift_next = {r_pshift[PW_TOTAL-PINDEX_WIDTH-1:0], i_pindex};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pshift <= '0;
            r_pword  <= '0;
        end else if (w_shift_en) begin
            r_pshift <= w_pshift_next;
            if (i_last) begin
                r_pword <= w_pshift_next;
            end
        end
    end

    assign o_pindex = r_pword;
`else
    logic w_unused_pindex;
    assign w_unused_pindex = ^i_pindex;
    assign o_pindex        = '0;
`endif

endmodule

// File: rtl/pe_ec_sched.sv
// Per-layer sequencer for one binary PE: issues (pos, ch) reads and packs results per position.
// PE_SCHED_PINDEX_EN enables capture of PE pool indices into out_pindex.
module pe_ec_sched
    import pe_ec_sched_pkg::*;
#(
    parameter int N_OUT_CH     = N_OUT_CH_DEF,
    parameter int POS_WIDTH    = 10,
    parameter int PINDEX_WIDTH = PINDEX_WIDTH_DEF,
    parameter int CH_WIDTH     = ch_width(N_OUT_CH)
)(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [POS_WIDTH-1:0]    cfg_n_pos,
    input  logic                    cfg_s,
    output logic                    busy,
    output logic                    done,
    output logic                    mem_re,
    output logic [POS_WIDTH-1:0]    win_addr,
    output logic [CH_WIDTH-1:0]     wt_addr,
    output logic [CH_WIDTH-1:0]     nref_addr,
    output logic                    pe_in_en,
    output logic                    pe_s,
    input  logic                    pe_data_out,
    input  logic [PINDEX_WIDTH-1:0] pe_pindex,
    pe_ec_sched_if.master           out_if
);
    sched_state_t         r_state;
    logic [POS_WIDTH-1:0] r_n_pos;
    logic [POS_WIDTH-1:0] r_pos;
    logic [CH_WIDTH-1:0]  r_ch;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_pe_s;
    logic                 r_zero_layer;
    logic                 r_s1_vld;
    logic                 r_s1_last;
    logic [POS_WIDTH-1:0] r_s1_pos;

    logic                             w_adv;
    logic                             w_issue;
    logic                             w_ch_last;
    logic                             w_pos_last;
    logic                             w_out_valid;
    logic [N_OUT_CH-1:0]              w_out_word;
    logic [POS_WIDTH-1:0]             w_out_pos;
    logic [N_OUT_CH*PINDEX_WIDTH-1:0] w_out_pindex;

    // The whole pipeline freezes only while a finished word is refused downstream.
    assign w_adv      = !(w_out_valid && !out_if.out_ready);
    assign w_issue    = (r_state == ST_RUN);
    assign w_ch_last  = (r_ch == CH_WIDTH'(N_OUT_CH - 1));
    assign w_pos_last = (r_pos == (r_n_pos - POS_WIDTH'(1)));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_n_pos      <= '0;
            r_pos        <= '0;
            r_ch         <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_pe_s       <= 1'b0;
            r_zero_layer <= 1'b0;
            r_s1_vld     <= 1'b0;
            r_s1_last    <= 1'b0;
            r_s1_pos     <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_n_pos      <= cfg_n_pos;
                        r_pe_s       <= cfg_s;
                        r_pos        <= '0;
                        r_ch         <= '0;
                        r_busy       <= 1'b1;
                        r_zero_layer <= (cfg_n_pos == '0);
                        r_state      <= (cfg_n_pos == '0) ? ST_DONE : ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (w_adv) begin
                        if (w_ch_last) begin
                            r_ch <= '0;
                            if (w_pos_last) begin
                                r_state <= ST_DRAIN;
                            end else begin
                                r_pos <= r_pos + POS_WIDTH'(1);
                            end
                        end else begin
                            r_ch <= r_ch + CH_WIDTH'(1);
                        end
                    end
                end
                ST_DRAIN: begin
                    // Stage 1 empty means the word now handing off is the layer's last.
                    if (!r_s1_vld && w_out_valid && out_if.out_ready) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                    end
                end
                ST_DONE: begin
                    r_state      <= ST_IDLE;
                    r_zero_layer <= 1'b0;
                    // An empty layer reports completion on the way out of DONE.
                    if (r_zero_layer) begin
                        r_done <= 1'b1;
                        r_busy <= 1'b0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase

            if (w_adv) begin
                r_s1_vld  <= w_issue;
                r_s1_last <= w_issue && w_ch_last;
                r_s1_pos  <= r_pos;
            end
        end
    end

    pe_sched_pack #(
        .N_OUT_CH    (N_OUT_CH),
        .POS_WIDTH   (POS_WIDTH),
        .PINDEX_WIDTH(PINDEX_WIDTH)
    ) u_pack (
        .clk     (clk),
        .rst     (rst),
        .i_adv   (w_adv),
        .i_in_en (r_s1_vld),
        .i_last  (r_s1_last),
        .i_pos   (r_s1_pos),
        .i_data  (pe_data_out),
        .i_pindex(pe_pindex),
        .i_ready (out_if.out_ready),
        .o_valid (w_out_valid),
        .o_word  (w_out_word),
        .o_pos   (w_out_pos),
        .o_pindex(w_out_pindex)
    );

    assign busy      = r_busy;
    assign done      = r_done;
    assign mem_re    = w_adv && w_issue;
    assign win_addr  = r_pos;
    assign wt_addr   = r_ch;
    assign nref_addr = r_ch;
    assign pe_in_en  = r_s1_vld;
    assign pe_s      = r_pe_s;

    assign out_if.out_valid  = w_out_valid;
    assign out_if.out_word   = w_out_word;
    assign out_if.out_pos    = w_out_pos;
    assign out_if.out_pindex = w_out_pindex;

endmodule

// File: tb/tb_pe_ec_sched.sv
// Randomized scoreboard bench for pe_ec_sched (4 channels); memories and PE modelled as tables.
`timescale 1ns/1ps
module tb_pe_ec_sched;
    localparam int N    = 4;
    localparam int PW   = 2;
    localparam int PWID = 6;
    localparam int CHW  = 2;

    logic            clk = 1'b0;
    logic            rst, start, cfg_s;
    logic [PWID-1:0] cfg_n_pos;
    logic            busy, done, mem_re, pe_in_en, pe_s, pe_data_out;
    logic [PWID-1:0] win_addr;
    logic [CHW-1:0]  wt_addr, nref_addr;
    logic [PW-1:0]   pe_pindex;

    pe_ec_sched_if #(.N_OUT_CH(N), .POS_WIDTH(PWID), .PINDEX_WIDTH(PW)) bus ();

    pe_ec_sched #(.N_OUT_CH(N), .POS_WIDTH(PWID), .PINDEX_WIDTH(PW), .CH_WIDTH(CHW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .cfg_n_pos  (cfg_n_pos),
        .cfg_s      (cfg_s),
        .busy       (busy),
        .done       (done),
        .mem_re     (mem_re),
        .win_addr   (win_addr),
        .wt_addr    (wt_addr),
        .nref_addr  (nref_addr),
        .pe_in_en   (pe_in_en),
        .pe_s       (pe_s),
        .pe_data_out(pe_data_out),
        .pe_pindex  (pe_pindex),
        .out_if     (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Memories with registered read that hold when mem_re is low; PE result is a table lookup.
    logic            tbl  [64][N];
    logic [PW-1:0]   ptbl [64][N];
    logic [PWID-1:0] m_pos = '0;
    logic [CHW-1:0]  m_ch  = '0;
    always @(posedge clk) if (mem_re) begin m_pos <= win_addr; m_ch <= wt_addr; end
    assign pe_data_out = pe_in_en ? tbl[m_pos][m_ch]  : 1'b0;
    assign pe_pindex   = pe_in_en ? ptbl[m_pos][m_ch] : '0;

    typedef struct {
        logic [PWID-1:0]   pos;
        logic [N-1:0]      word;
        logic [N*PW-1:0]   pidx;
    } exp_t;

    exp_t exp_q[$];
    int   hs_q[$];
    exp_t mon_e;
    int   n_cmp = 0, n_fail = 0;
    int   issue_idx = 0, issue_total = 0;
    int   first_valid_cyc = -1, done_cyc = -1;
    bit   mon_en = 1'b0;

    task automatic check(input string name, input longint act, input longint req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: addresses follow the issue order; stalls freeze reads; words pop the scoreboard.
    always @(negedge clk) begin
        if (mon_en && !rst) begin
            if (mem_re) begin
                if (issue_idx >= issue_total) begin
                    n_cmp++; n_fail++;
                    $display("FAIL issue_extra: got read pos=%0d ch=%0d, expected none", win_addr, wt_addr);
                end else begin
                    check("issue_win", win_addr, issue_idx / N);
                    check("issue_wt", wt_addr, issue_idx % N);
                    check("issue_nref", nref_addr, issue_idx % N);
                    issue_idx++;
                end
            end
            if (bus.out_valid && !bus.out_ready) begin
                check("stall_mem_re", mem_re, 0);
                if (issue_idx < issue_total) begin
                    check("stall_win", win_addr, issue_idx / N);
                    check("stall_wt", wt_addr, issue_idx % N);
                end
            end
            if (bus.out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++; n_fail++;
                    $display("FAIL extra_word: got pos=%0d word=%b, expected none", bus.out_pos, bus.out_word);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("out_word", bus.out_word, mon_e.word);
                    check("out_pos", bus.out_pos, mon_e.pos);
                    check("out_pindex", bus.out_pindex, mon_e.pidx);
                    hs_q.push_back(cyc);
                    $display("xfer cyc=%0d pos=%0d word=%b pidx=%h", cyc, bus.out_pos, bus.out_word, bus.out_pindex);
                end
            end
            if (done) begin
                done_cyc = cyc;
                check("done_busy_low", busy, 0);
            end
        end
    end

    task automatic load_layer(input int n, input bit directed);
        exp_t e;
        for (int p = 0; p < n; p++)
            for (int c = 0; c < N; c++) begin
                tbl[p][c]  = 1'($urandom_range(0, 1));
                ptbl[p][c] = PW'($urandom_range(0, 3));
            end
        if (directed) begin
            tbl[0][0] = 1'b1; tbl[0][1] = 1'b0; tbl[0][2] = 1'b1; tbl[0][3] = 1'b1;
            ptbl[0][0] = 2'd3; ptbl[0][1] = 2'd0; ptbl[0][2] = 2'd2; ptbl[0][3] = 2'd1;
        end
        for (int p = 0; p < n; p++) begin
            e.pos  = PWID'(p);
            e.word = '0;
            e.pidx = '0;
            for (int c = 0; c < N; c++) begin
                e.word = e.word | ((N)'(tbl[p][c]) << (N - 1 - c));
`ifdef PE_SCHED_PINDEX_EN
                e.pidx = e.pidx | ((N*PW)'(ptbl[p][c]) << ((N - 1 - c) * PW));
`endif
            end
            exp_q.push_back(e);
        end
        issue_idx = 0; issue_total = n * N;
        first_valid_cyc = -1; done_cyc = -1;
        hs_q.delete();
    endtask

    // mode 0: ready high; 1: random ready; 2: ready low for 5 cycles from first word.
    task automatic run_layer(input int n, input int mode, input bit directed, input bit poke);
        int t0;
        bit s;
        load_layer(n, directed);
        s = 1'($urandom_range(0, 1));
        bus.out_ready = (mode != 1) ? 1'b1 : 1'($urandom_range(0, 1));
        cfg_n_pos = PWID'(n); cfg_s = s; start = 1'b1;
        t0 = cyc;
        tick();
        start = 1'b0; cfg_n_pos = PWID'($urandom_range(0, 63)); cfg_s = !s;
        check("busy_after_start", busy, 1);
        check("pe_s_latched", pe_s, s);
        for (int b = 0; b < 1000 && done_cyc < 0; b++) begin
            case (mode)
                0:       bus.out_ready = 1'b1;
                1:       bus.out_ready = ($urandom_range(0, 9) < 7);
                default: bus.out_ready = !(cyc >= t0 + N + 2 && cyc <= t0 + N + 6);
            endcase
            if (poke && cyc == t0 + 3) begin start = 1'b1; cfg_n_pos = 6'd5; end
            else start = 1'b0;
            tick();
        end
        start = 1'b0;
        if (done_cyc < 0) begin
            n_cmp++; n_fail++;
            $display("FAIL done_timeout: got no done, expected done for n_pos=%0d", n);
        end else if (n == 0) begin
            check("done_lat_zero", done_cyc, t0 + 2);
        end else begin
            check("done_after_last_word", done_cyc, hs_q[hs_q.size()-1] + 1);
        end
        check("words_left", exp_q.size(), 0);
        check("issue_count", issue_idx, issue_total);
        if (mode != 1 && n > 0) check("first_valid_lat", first_valid_cyc, t0 + N + 2);
        if (mode == 0)
            for (int i = 1; i < hs_q.size(); i++) check("word_spacing", hs_q[i] - hs_q[i-1], N);
        bus.out_ready = 1'b1;
        tick(); tick();
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_mem_re"}, mem_re, 0);
        check({tag, "_win_addr"}, win_addr, 0);
        check({tag, "_wt_addr"}, wt_addr, 0);
        check({tag, "_nref_addr"}, nref_addr, 0);
        check({tag, "_pe_in_en"}, pe_in_en, 0);
        check({tag, "_pe_s"}, pe_s, 0);
        check({tag, "_out_valid"}, bus.out_valid, 0);
        check({tag, "_out_word"}, bus.out_word, 0);
        check({tag, "_out_pos"}, bus.out_pos, 0);
        check({tag, "_out_pindex"}, bus.out_pindex, 0);
    endtask

    task automatic reset_mid();
        int b;
        load_layer(3, 1'b0);
        bus.out_ready = 1'b1;
        cfg_n_pos = 6'd3; cfg_s = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        for (b = 0; b < 50 && issue_idx < N + 1; b++) tick();
        check("reached_second_pos", issue_idx >= N + 1, 1);
        rst = 1'b1;
        tick();
        check_zero("mid_rst");
        rst = 1'b0;
        exp_q.delete();
        issue_idx = 0; issue_total = 0;
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; cfg_n_pos = '0; cfg_s = 1'b0; bus.out_ready = 1'b0;
        repeat (3) tick();
        check_zero("reset");
        rst = 1'b0;
        tick();
        mon_en = 1'b1;
        run_layer(1, 0, 1'b1, 1'b0);
        run_layer(3, 0, 1'b0, 1'b0);
        run_layer(3, 2, 1'b0, 1'b0);
        run_layer(0, 0, 1'b0, 1'b0);
        run_layer(3, 0, 1'b0, 1'b1);
        reset_mid();
        run_layer(2, 0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) run_layer($urandom_range(0, 6), 1, 1'b0, 1'b0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
